// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO traffic generator/checker pair: checker states,
// default widths and the sequence-advance rule used by both ends of the FIFO.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 32;
  localparam int FIFO_SEQ_START  = 1;
  // Widest data path next_seq() can serve; callers zero-extend into it.
  localparam int SEQ_MAX_W       = 64;

  typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_e;

  typedef logic [SEQ_MAX_W-1:0] seq_word_t;

  // Increment modulo 2^width, skipping 0 so the traffic never carries a zero word.
  function automatic seq_word_t next_seq(input seq_word_t x, input int unsigned width);
    seq_word_t mask;
    seq_word_t r;
    mask = (width >= SEQ_MAX_W) ? '1 : ((seq_word_t'(1) << width) - seq_word_t'(1));
    r    = (x + seq_word_t'(1)) & mask;
    if (r == '0) r = seq_word_t'(1);
    return r;
  endfunction

endpackage

// File: rtl/fifo_ack_throttle.sv
// Rotating 8-bit acceptance pattern: bit 0 gates the consumer's ack, the pattern
// rotates right once per active cycle. A zero pattern would never ack, so it loads as all-ones.
module fifo_ack_throttle (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       advance_i,
  input  logic [7:0] pattern_i,
  output logic       next_bit_o
);

  logic [7:0] pattern_q;
  logic [7:0] pattern_d;

  always_comb begin
    pattern_d = pattern_q;
    if (load_i) begin
      pattern_d = (pattern_i == 8'h00) ? 8'hFF : pattern_i;
    end else if (advance_i) begin
      pattern_d = {pattern_q[0], pattern_q[7:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pattern_q <= 8'h00;
    end else begin
      pattern_q <= pattern_d;
    end
  end

  // Exposing the next bit lets the owner register ack without an extra cycle of lag.
  assign next_bit_o = pattern_d[0];

endmodule

// File: rtl/fifo_seq_checker.sv
// Read-side FIFO consumer: drains words through valid/ack with a throttled ack and
// checks them against the 1,2,3,... traffic sequence, reporting counts and the first mismatch.
module fifo_seq_checker
  import fifo_pkg::*;
#(
  parameter int                    DATA_WIDTH    = FIFO_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] SEQ_START     = DATA_WIDTH'(FIFO_SEQ_START),
  parameter int unsigned           EXPECT_WORDS  = 0,
  parameter int                    ERR_CNT_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [7:0]               ack_pattern,
  input  logic [DATA_WIDTH-1:0]    data_out,
  input  logic                     data_out_valid,
  output logic                     data_out_ack,
  output logic [31:0]              word_count,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic                     error,
  output logic [DATA_WIDTH-1:0]    first_err_expected,
  output logic [DATA_WIDTH-1:0]    first_err_actual,
  output logic                     done
);

  chk_state_e               state_q;
  logic                     ack_q;
  logic [31:0]              word_count_q;
  logic [ERR_CNT_WIDTH-1:0] error_count_q;
  logic                     error_q;
  logic [DATA_WIDTH-1:0]    first_exp_q;
  logic [DATA_WIDTH-1:0]    first_act_q;
  logic                     done_q;
  logic [DATA_WIDTH-1:0]    expected_q;

  logic                     start;
  logic                     xfer;
  logic                     mismatch;
  logic                     last_word;
  logic                     ack_next;
  logic [DATA_WIDTH-1:0]    expected_next;

  assign start     = (state_q == IDLE) && enable;
  assign xfer      = (state_q == RUN) && ack_q && data_out_valid;
  assign mismatch  = (data_out != expected_q);
  assign last_word = (EXPECT_WORDS != 0) && ((word_count_q + 32'd1) == 32'(EXPECT_WORDS));
  // Following the received word (not the expected one) resyncs after a drop,
  // so a single missing word costs exactly one error.
  assign expected_next = DATA_WIDTH'(next_seq(SEQ_MAX_W'(data_out), DATA_WIDTH));

  fifo_ack_throttle u_throttle (
    .clk_i      (clock),
    .rst_i      (rst),
    .load_i     (start),
    .advance_i  (state_q == RUN),
    .pattern_i  (ack_pattern),
    .next_bit_o (ack_next)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= IDLE;
      ack_q         <= 1'b0;
      word_count_q  <= '0;
      error_count_q <= '0;
      error_q       <= 1'b0;
      first_exp_q   <= '0;
      first_act_q   <= '0;
      done_q        <= 1'b0;
      expected_q    <= SEQ_START;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          if (enable) begin
            state_q       <= RUN;
            ack_q         <= ack_next;
            word_count_q  <= '0;
            error_count_q <= '0;
            error_q       <= 1'b0;
            first_exp_q   <= '0;
            first_act_q   <= '0;
            done_q        <= 1'b0;
            expected_q    <= SEQ_START;
          end
        end
        RUN: begin
          if (xfer) begin
            word_count_q <= word_count_q + 32'd1;
            expected_q   <= expected_next;
            if (mismatch) begin
              if (error_count_q != '1) error_count_q <= error_count_q + ERR_CNT_WIDTH'(1);
              if (!error_q) begin
                error_q     <= 1'b1;
                first_exp_q <= expected_q;
                first_act_q <= data_out;
              end
            end
          end
          // Dropping ack in the same edge as the final transfer prevents an extra word.
          if (xfer && last_word) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            ack_q   <= 1'b0;
          end else if (!enable) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end else begin
            ack_q <= ack_next;
          end
        end
        DONE: begin
          ack_q <= 1'b0;
          if (!enable) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign data_out_ack       = ack_q;
  assign word_count         = word_count_q;
  assign error_count        = error_count_q;
  assign error              = error_q;
  assign first_err_expected = first_exp_q;
  assign first_err_actual   = first_act_q;
  assign done               = done_q;

endmodule

// File: tb/tb_fifo_seq_checker.sv
// Directed bench for fifo_seq_checker: one instance with a 16-word target and one
// starting near the top of the 32-bit range to exercise the zero-skipping wrap.
module tb_fifo_seq_checker;

  logic        clk = 1'b0;
  logic        rst;

  logic        en_a, vld_a, ack_a, err_a, done_a;
  logic [7:0]  pat_a;
  logic [31:0] dat_a, wc_a, fex_a, fac_a;
  logic [15:0] ec_a;

  logic        en_b, vld_b, ack_b, err_b, done_b;
  logic [7:0]  pat_b;
  logic [31:0] dat_b, wc_b, fex_b, fac_b;
  logic [15:0] ec_b;

  int total = 0;
  int bad   = 0;
  int cyc;
  logic [31:0] src[$];

  always #5 clk = ~clk;

  fifo_seq_checker #(
    .DATA_WIDTH(32), .SEQ_START(32'd1), .EXPECT_WORDS(16), .ERR_CNT_WIDTH(16)
  ) dut_a (
    .clock(clk), .rst(rst), .enable(en_a), .ack_pattern(pat_a),
    .data_out(dat_a), .data_out_valid(vld_a), .data_out_ack(ack_a),
    .word_count(wc_a), .error_count(ec_a), .error(err_a),
    .first_err_expected(fex_a), .first_err_actual(fac_a), .done(done_a)
  );

  fifo_seq_checker #(
    .DATA_WIDTH(32), .SEQ_START(32'hFFFF_FFFE), .EXPECT_WORDS(0), .ERR_CNT_WIDTH(16)
  ) dut_b (
    .clock(clk), .rst(rst), .enable(en_b), .ack_pattern(pat_b),
    .data_out(dat_b), .data_out_valid(vld_b), .data_out_ack(ack_b),
    .word_count(wc_b), .error_count(ec_b), .error(err_b),
    .first_err_expected(fex_b), .first_err_actual(fac_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents queued words on the selected instance; a word leaves the queue on an
  // edge where ack (stable between edges) and valid were both high.
  task automatic run_stream(input bit sel, input int budget, output int cycles);
    bit ack_now;
    cycles = 0;
    while (src.size() != 0 && cycles < budget) begin
      ack_now = sel ? ack_b : ack_a;
      if (sel) begin vld_b = 1'b1; dat_b = src[0]; end
      else     begin vld_a = 1'b1; dat_a = src[0]; end
      tick();
      cycles++;
      if (ack_now) void'(src.pop_front());
    end
    vld_a = 1'b0;
    vld_b = 1'b0;
    chk("drain_left", 64'(src.size()), 64'd0);
    src.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    en_a = 0; vld_a = 0; pat_a = 0; dat_a = 0;
    en_b = 0; vld_b = 0; pat_b = 0; dat_b = 0;
    repeat (3) tick();
    rst = 1'b0;

    // Idle with valid offered: nothing must be accepted.
    vld_a = 1'b1; dat_a = 32'd1;
    tick(); tick();
    chk("idle_ack",   64'(ack_a),  64'd0);
    chk("idle_wc",    64'(wc_a),   64'd0);
    chk("idle_ec",    64'(ec_a),   64'd0);
    chk("idle_err",   64'(err_a),  64'd0);
    chk("idle_fex",   64'(fex_a),  64'd0);
    chk("idle_fac",   64'(fac_a),  64'd0);
    chk("idle_done",  64'(done_a), 64'd0);

    // Clean stream of 16 with full-rate ack: 1 idle cycle + 16 transfers.
    pat_a = 8'hFF;
    for (int i = 1; i <= 16; i++) src.push_back(32'(i));
    en_a = 1'b1;
    run_stream(1'b0, 40, cyc);
    chk("clean_cycles", 64'(cyc),    64'd17);
    chk("clean_wc",     64'(wc_a),   64'd16);
    chk("clean_ec",     64'(ec_a),   64'd0);
    chk("clean_err",    64'(err_a),  64'd0);
    chk("clean_done",   64'(done_a), 64'd1);
    chk("clean_ack",    64'(ack_a),  64'd0);
    vld_a = 1'b1; dat_a = 32'd17;
    tick();
    chk("done_hold_wc", 64'(wc_a),   64'd16);
    vld_a = 1'b0; en_a = 1'b0;
    tick();

    // Alternating ack: 8 words take 1 idle + 15 run cycles.
    pat_a = 8'b0101_0101;
    for (int i = 1; i <= 8; i++) src.push_back(32'(i));
    en_a = 1'b1;
    run_stream(1'b0, 40, cyc);
    chk("thr_cycles", 64'(cyc),    64'd16);
    chk("thr_wc",     64'(wc_a),   64'd8);
    chk("thr_ec",     64'(ec_a),   64'd0);
    chk("thr_ack",    64'(ack_a),  64'd0);
    chk("thr_done",   64'(done_a), 64'd0);
    en_a = 1'b0;
    tick();

    // Dropped word 4: one error, then resync on 5.
    pat_a = 8'hFF;
    src = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd6, 32'd7};
    en_a = 1'b1;
    run_stream(1'b0, 20, cyc);
    chk("drop_wc",  64'(wc_a),  64'd6);
    chk("drop_ec",  64'(ec_a),  64'd1);
    chk("drop_err", 64'(err_a), 64'd1);
    chk("drop_fex", 64'(fex_a), 64'd4);
    chk("drop_fac", 64'(fac_a), 64'd5);
    en_a = 1'b0;
    tick();

    // Abort after 5 words, hold in idle, then restart clears.
    for (int i = 1; i <= 5; i++) src.push_back(32'(i));
    en_a = 1'b1;
    run_stream(1'b0, 20, cyc);
    en_a = 1'b0;
    tick();
    chk("abort_ack",   64'(ack_a), 64'd0);
    chk("abort_wc",    64'(wc_a),  64'd5);
    tick();
    chk("abort_hold",  64'(wc_a),  64'd5);
    en_a = 1'b1;
    tick();
    chk("restart_wc",  64'(wc_a),  64'd0);
    chk("restart_err", 64'(err_a), 64'd0);
    for (int i = 1; i <= 3; i++) src.push_back(32'(i));
    run_stream(1'b0, 20, cyc);
    chk("restart_wc3", 64'(wc_a),  64'd3);
    chk("run_ack_hi",  64'(ack_a), 64'd1);
    rst = 1'b1; vld_a = 1'b1; dat_a = 32'd4;
    tick();
    chk("rst_ack",  64'(ack_a),  64'd0);
    chk("rst_wc",   64'(wc_a),   64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    rst = 1'b0; vld_a = 1'b0; en_a = 1'b0;
    tick();

    // Wrap past zero; pattern 0 behaves as all-ones.
    pat_b = 8'h00;
    src = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd2};
    en_b = 1'b1;
    run_stream(1'b1, 20, cyc);
    chk("wrap_cycles", 64'(cyc),    64'd5);
    chk("wrap_wc",     64'(wc_b),   64'd4);
    chk("wrap_ec",     64'(ec_b),   64'd0);
    chk("wrap_done",   64'(done_b), 64'd0);
    en_b = 1'b0;
    tick();
    src = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0};
    en_b = 1'b1;
    run_stream(1'b1, 20, cyc);
    chk("zero_err", 64'(err_b), 64'd1);
    chk("zero_ec",  64'(ec_b),  64'd1);
    chk("zero_fex", 64'(fex_b), 64'd1);
    chk("zero_fac", 64'(fac_b), 64'd0);
    en_b = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
